mem_arbiter: RTL and testbench

Arbiter that shares one single-port synchronous memory between the instruction-fetch port and the data (load/store) port of the openmips core. It replaces separate ROM/RAM buses with one physical memory. It serialises accesses through a small FSM and drives a stall request into ctrl while either port is waiting. Data accesses win simultaneous contention. A fairness rule prevents instruction fetch from starving.

---
 rtl/mem_arbiter.sv | 118 +++++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port synchronous memory
// between the fetch port and the load/store port.
module mem_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_sel,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_ce_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_sel_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        IDLE,
        I_ACC,
        D_ACC,
        ACK
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(WAIT_STATES);

    state_t     state;
    logic [2:0] cnt;
    logic       d_elig;
    logic       i_elig;

    // The port just acked sits out one arbitration round.
    always_comb begin
        d_elig = d_req;
        i_elig = i_req;
        if (state == ACK) begin
            d_elig = d_req & ~d_ack;
            i_elig = i_req & ~i_ack;
        end
    end

    assign stallreq_o = (i_req & ~i_ack) | (d_req & ~d_ack);

    // Access FSM; the mem_* registers double as the latched request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            mem_ce_o   <= 1'b0;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= 4'b0;
            mem_addr_o <= 32'b0;
            mem_data_o <= 32'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= 32'b0;
            d_rdata    <= 32'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            unique case (state)
                IDLE, ACK: begin
                    mem_ce_o <= 1'b0;
                    mem_we_o <= 1'b0;
                    if (d_elig) begin
                        state      <= D_ACC;
                        cnt        <= CNT_INIT;
                        mem_ce_o   <= 1'b1;
                        mem_we_o   <= d_we;
                        mem_sel_o  <= d_sel;
                        mem_addr_o <= d_addr;
                        mem_data_o <= d_wdata;
                    end else if (i_elig) begin
                        state      <= I_ACC;
                        cnt        <= CNT_INIT;
                        mem_ce_o   <= 1'b1;
                        mem_we_o   <= 1'b0;
                        mem_sel_o  <= 4'b1111;
                        mem_addr_o <= i_addr;
                        mem_data_o <= 32'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                I_ACC, D_ACC: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end else begin
                        state    <= ACK;
                        mem_ce_o <= 1'b0;
                        mem_we_o <= 1'b0;
                        if (state == I_ACC) begin
                            i_rdata <= mem_data_i;
                            i_ack   <= 1'b1;
                        end else begin
                            if (!mem_we_o) begin
                                d_rdata <= mem_data_i;
                            end
                            d_ack <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter
// with WAIT_STATES=1 (dut) and WAIT_STATES=0 (dut0).
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [3:0]  d_sel;
    logic [31:0] i_rdata, d_rdata;
    logic        i_ack, d_ack;
    logic        mem_ce_o, mem_we_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
    logic        stallreq_o;

    logic        z_i_req;
    logic [31:0] z_i_addr;
    logic [31:0] z_i_rdata, z_d_rdata;
    logic        z_i_ack, z_d_ack;
    logic        z_ce, z_we;
    logic [3:0]  z_sel;
    logic [31:0] z_addr, z_wdat, z_mdi;
    logic        z_stall;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Memory content: 0x10 holds a fixed word, others {addr[15:0], BEEF}.
    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h10) return 32'h3C010101;
        return {a[15:0], 16'hBEEF};
    endfunction

    assign mem_data_i = mem_ce_o ? memword(mem_addr_o) : 32'h0;
    assign z_mdi      = z_ce ? memword(z_addr) : 32'h0;

    mem_arbiter #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_sel(d_sel),
        .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
        .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i),
        .stallreq_o(stallreq_o)
    );

    mem_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .i_req(z_i_req), .i_addr(z_i_addr),
        .i_rdata(z_i_rdata), .i_ack(z_i_ack),
        .d_req(1'b0), .d_we(1'b0), .d_sel(4'b0),
        .d_addr(32'h0), .d_wdata(32'h0),
        .d_rdata(z_d_rdata), .d_ack(z_d_ack),
        .mem_ce_o(z_ce), .mem_we_o(z_we),
        .mem_sel_o(z_sel), .mem_addr_o(z_addr),
        .mem_data_o(z_wdat), .mem_data_i(z_mdi),
        .stallreq_o(z_stall)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; d_sel = 0;
        z_i_req = 0; z_i_addr = 0;
        repeat (2) cyc();
        check("rst_ce", 32'(mem_ce_o), 0);
        check("rst_we", 32'(mem_we_o), 0);
        check("rst_sel", 32'(mem_sel_o), 0);
        check("rst_addr", mem_addr_o, 0);
        check("rst_wdata", mem_data_o, 0);
        check("rst_acks", {30'b0, i_ack, d_ack}, 0);
        check("rst_irdata", i_rdata, 0);
        check("rst_drdata", d_rdata, 0);
        check("rst_stall", 32'(stallreq_o), 0);
        rst = 1'b0;
        cyc();

        // Single fetch, WAIT_STATES=1
        i_req = 1; i_addr = 32'h10;
        #1 check("f_stall_c0", 32'(stallreq_o), 1);
        cyc();
        i_addr = 32'h99;
        check("f_ce_c1", 32'(mem_ce_o), 1);
        check("f_addr_c1", mem_addr_o, 32'h10);
        check("f_sel_c1", 32'(mem_sel_o), 32'hF);
        check("f_stall_c1", 32'(stallreq_o), 1);
        cyc();
        check("f_ce_c2", 32'(mem_ce_o), 1);
        check("f_addr_c2", mem_addr_o, 32'h10);
        check("f_ack_c2", 32'(i_ack), 0);
        check("f_stall_c2", 32'(stallreq_o), 1);
        cyc();
        check("f_ack_c3", 32'(i_ack), 1);
        check("f_rdata_c3", i_rdata, 32'h3C010101);
        check("f_ce_c3", 32'(mem_ce_o), 0);
        check("f_stall_c3", 32'(stallreq_o), 0);
        i_req = 0;
        cyc();
        check("f_ack_c4", 32'(i_ack), 0);
        check("f_ce_c4", 32'(mem_ce_o), 0);

        // Contention: data wins, fetch from ACK
        i_req = 1; i_addr = 32'h14;
        d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h100;
        cyc();
        check("c_addr_c1", mem_addr_o, 32'h100);
        check("c_we_c1", 32'(mem_we_o), 0);
        cyc();
        check("c_addr_c2", mem_addr_o, 32'h100);
        cyc();
        check("c_dack_c3", 32'(d_ack), 1);
        check("c_iack_c3", 32'(i_ack), 0);
        check("c_drdata", d_rdata, 32'h0100BEEF);
        d_req = 0;
        cyc();
        check("c_ce_c4", 32'(mem_ce_o), 1);
        check("c_addr_c4", mem_addr_o, 32'h14);
        check("c_dack_c4", 32'(d_ack), 0);
        cyc();
        check("c_addr_c5", mem_addr_o, 32'h14);
        cyc();
        check("c_iack_c6", 32'(i_ack), 1);
        check("c_irdata", i_rdata, 32'h0014BEEF);
        check("c_drdata_hold", d_rdata, 32'h0100BEEF);
        i_req = 0;
        cyc();

        // Byte-masked write
        d_req = 1; d_we = 1; d_sel = 4'b0011;
        d_addr = 32'h20; d_wdata = 32'h0000ABCD;
        cyc();
        d_wdata = 32'hFFFFFFFF; d_sel = 4'hF;
        for (int c = 1; c <= 2; c++) begin
            check("w_ce", 32'(mem_ce_o), 1);
            check("w_we", 32'(mem_we_o), 1);
            check("w_sel", 32'(mem_sel_o), 32'h3);
            check("w_addr", mem_addr_o, 32'h20);
            check("w_data", mem_data_o, 32'h0000ABCD);
            check("w_dack_early", 32'(d_ack), 0);
            cyc();
        end
        check("w_dack", 32'(d_ack), 1);
        check("w_we_ack", 32'(mem_we_o), 0);
        check("w_drdata_keep", d_rdata, 32'h0100BEEF);
        d_req = 0; d_we = 0;
        cyc();

        // Both held: grants alternate D, I, D, ...
        i_req = 1; i_addr = 32'h14;
        d_req = 1; d_addr = 32'h100; d_sel = 4'hF;
        for (int c = 1; c <= 21; c++) begin
            cyc();
            check("fair_dack", 32'(d_ack),
                  32'((c % 3 == 0) && ((c / 3) % 2 == 1)));
            check("fair_iack", 32'(i_ack),
                  32'((c % 3 == 0) && ((c / 3) % 2 == 0)));
        end
        i_req = 0; d_req = 0;
        cyc();

        // Reset in the second D_ACC cycle
        d_req = 1; d_addr = 32'h104;
        cyc();
        cyc();
        check("r_ce_c2", 32'(mem_ce_o), 1);
        rst = 1;
        cyc();
        check("r_dack", 32'(d_ack), 0);
        check("r_ce", 32'(mem_ce_o), 0);
        check("r_addr", mem_addr_o, 0);
        check("r_sel", 32'(mem_sel_o), 0);
        check("r_drdata", d_rdata, 0);
        check("r_irdata", i_rdata, 0);
        rst = 0;
        cyc();
        check("r_ce_c4", 32'(mem_ce_o), 1);
        check("r_addr_c4", mem_addr_o, 32'h104);
        check("r_dack_c4", 32'(d_ack), 0);
        cyc();
        check("r_dack_c5", 32'(d_ack), 0);
        cyc();
        check("r_dack_c6", 32'(d_ack), 1);
        check("r_drdata_c6", d_rdata, 32'h0104BEEF);
        d_req = 0;
        cyc();

        // WAIT_STATES=0 single fetch
        z_i_req = 1; z_i_addr = 32'h10;
        cyc();
        check("z_ce_c1", 32'(z_ce), 1);
        check("z_addr_c1", z_addr, 32'h10);
        check("z_ack_c1", 32'(z_i_ack), 0);
        cyc();
        check("z_ce_c2", 32'(z_ce), 0);
        check("z_ack_c2", 32'(z_i_ack), 1);
        check("z_rdata_c2", z_i_rdata, 32'h3C010101);
        z_i_req = 0;
        cyc();
        check("z_ack_c3", 32'(z_i_ack), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
